// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator: N pulses of programmable high width and low gap on a registered output.
// Optional abort input is enabled by defining PULSE_TRAIN_GEN_ABORT_EN.
module pulse_train_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             ena,
    input  logic             start,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    input  logic             abort,
`endif
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [CNT_W-1:0] count,
    output logic             out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   phase, phase_n;
    logic [CNT_W-1:0]   pulses, pulses_n;
    logic [CNT_W-1:0]   hi_term, hi_term_n;
    logic [CNT_W-1:0]   lo_term, lo_term_n;
    logic [CNT_W-1:0]   count_r, count_n;
    logic               out_n;
    logic               done_n;
    logic               abort_hit;
    logic [CNT_W-1:0]   pulse_inc;

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign pulse_inc = pulses + 1'b1;
    assign busy      = (state != IDLE);

    // Phase lengths are stored as terminal counts so a zero length behaves as one cycle.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        pulses_n  = pulses;
        hi_term_n = hi_term;
        lo_term_n = lo_term;
        count_n   = count_r;
        out_n     = out;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = HIGH;
                    out_n     = 1'b1;
                    phase_n   = '0;
                    pulses_n  = '0;
                    hi_term_n = (high_len == '0) ? '0 : high_len - 1'b1;
                    lo_term_n = (low_len == '0) ? '0 : low_len - 1'b1;
                    count_n   = count;
                end
            end
            HIGH: begin
                if (abort_hit) begin
                    state_n = IDLE;
                    out_n   = 1'b0;
                    done_n  = 1'b1;
                end else if (phase == hi_term) begin
                    pulses_n = pulse_inc;
                    phase_n  = '0;
                    out_n    = 1'b0;
                    if ((count_r != '0) && (pulse_inc == count_r)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = LOW;
                    end
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            LOW: begin
                if (abort_hit) begin
                    state_n = IDLE;
                    out_n   = 1'b0;
                    done_n  = 1'b1;
                end else if (phase == lo_term) begin
                    state_n = HIGH;
                    phase_n = '0;
                    out_n   = 1'b1;
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                out_n   = 1'b0;
            end
        endcase
    end

    // With ena low everything holds except the done strobe, which must not stretch.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            phase   <= '0;
            pulses  <= '0;
            hi_term <= '0;
            lo_term <= '0;
            count_r <= '0;
            out     <= 1'b0;
            done    <= 1'b0;
        end else if (ena) begin
            state   <= state_n;
            phase   <= phase_n;
            pulses  <= pulses_n;
            hi_term <= hi_term_n;
            lo_term <= lo_term_n;
            count_r <= count_n;
            out     <= out_n;
            done    <= done_n;
        end else begin
            done    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Testbench for pulse_train_gen: directed vector table, hand sequences and a randomized run
// against a waveform-queue reference model.
module tb_pulse_train_gen;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         nrst, ena, start, abort;
    logic [W-1:0] high_len, low_len, count;
    logic         out, busy, done;

    int checks = 0;
    int errors = 0;

    pulse_train_gen #(.CNT_W(W)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .ena      (ena),
        .start    (start),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
        .abort    (abort),
`endif
        .high_len (high_len),
        .low_len  (low_len),
        .count    (count),
        .out      (out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         nrst, ena, start;
        logic [W-1:0] hl, ll, cnt;
        logic         eo, eb, ed;
    } vec_t;

    vec_t vecs[$];

    // Reference model: expected out values per enabled edge of the running train.
    logic q[$];
    bit   m_active = 0;
    bit   m_cont   = 0;
    logic m_out    = 0;
    logic m_done   = 0;
    int   m_h, m_l;

    task automatic applyStimulus(input logic n, input logic e, input logic s,
                                 input logic [W-1:0] hl, input logic [W-1:0] ll,
                                 input logic [W-1:0] c);
        nrst = n; ena = e; start = s; high_len = hl; low_len = ll; count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic addVec(input logic n, input logic e, input logic s, input int hl,
                          input int ll, input int c, input logic eo, input logic eb,
                          input logic ed);
        vec_t v;
        v.nrst = n; v.ena = e; v.start = s;
        v.hl = W'(hl); v.ll = W'(ll); v.cnt = W'(c);
        v.eo = eo; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic pushPulse();
        for (int i = 0; i < m_h; i++) q.push_back(1'b1);
        for (int i = 0; i < m_l; i++) q.push_back(1'b0);
    endtask

    task automatic modelStep(input logic n, input logic e, input logic s, input logic ab,
                             input logic [W-1:0] hl, input logic [W-1:0] ll,
                             input logic [W-1:0] c);
        if (!n) begin
            q.delete(); m_active = 0; m_out = 0; m_done = 0;
        end else if (e) begin
            m_done = 0;
            if (m_active && ab) begin
                q.delete(); m_active = 0; m_out = 0; m_done = 1;
            end else if (m_active) begin
                if (q.size() == 0) begin
                    m_active = 0; m_out = 0; m_done = 1;
                end else begin
                    m_out = q.pop_front();
                    if (m_cont && q.size() == 0) pushPulse();
                end
            end else if (s) begin
                m_h = (hl == 0) ? 1 : int'(hl);
                m_l = (ll == 0) ? 1 : int'(ll);
                m_cont = (c == 0);
                if (m_cont) pushPulse();
                else begin
                    for (int p = 0; p < int'(c); p++) begin
                        for (int i = 0; i < m_h; i++) q.push_back(1'b1);
                        if (p < int'(c) - 1)
                            for (int i = 0; i < m_l; i++) q.push_back(1'b0);
                    end
                end
                m_out = q.pop_front();
                m_active = 1;
                if (m_cont && q.size() == 0) pushPulse();
            end
        end else begin
            m_done = 0;
        end
    endtask

    initial begin
        int hi_cycles;
        logic r_n, r_e, r_s, r_a;
        logic [W-1:0] r_hl, r_ll, r_c;

        abort = 1'b0;
        nrst = 1'b0; ena = 1'b1; start = 1'b0;
        high_len = '0; low_len = '0; count = '0;

        // Reset with start held, basic train, ignored start, then back-to-back zero-length train.
        addVec(0,1,1, 3,2,2, 0,0,0);
        addVec(0,1,1, 3,2,2, 0,0,0);
        addVec(0,1,1, 3,2,2, 0,0,0);
        addVec(1,1,0, 3,2,2, 0,0,0);
        addVec(1,1,1, 3,2,2, 1,1,0);
        addVec(1,1,0, 7,7,9, 1,1,0);
        addVec(1,1,0, 7,7,9, 1,1,0);
        addVec(1,1,0, 7,7,9, 0,1,0);
        addVec(1,1,0, 7,7,9, 0,1,0);
        addVec(1,1,1, 7,7,9, 1,1,0);
        addVec(1,1,0, 7,7,9, 1,1,0);
        addVec(1,1,0, 7,7,9, 1,1,0);
        addVec(1,1,0, 7,7,9, 0,0,1);
        addVec(1,1,1, 0,0,4, 1,1,0);
        addVec(1,1,0, 0,0,4, 0,1,0);
        addVec(1,1,0, 0,0,4, 1,1,0);
        addVec(1,1,0, 0,0,4, 0,1,0);
        addVec(1,1,0, 0,0,4, 1,1,0);
        addVec(1,1,0, 0,0,4, 0,1,0);
        addVec(1,1,0, 0,0,4, 1,1,0);
        addVec(1,1,0, 0,0,4, 0,0,1);
        addVec(1,1,0, 0,0,4, 0,0,0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].nrst, vecs[i].ena, vecs[i].start,
                          vecs[i].hl, vecs[i].ll, vecs[i].cnt);
            checkOutput($sformatf("vec%0d_out", i),  out,  vecs[i].eo);
            checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].eb);
            checkOutput($sformatf("vec%0d_done", i), done, vecs[i].ed);
        end

        // ena gating mid-HIGH stretches the high phase, then reset mid-LOW.
        applyStimulus(0,1,0, 5,5,0);
        applyStimulus(1,1,1, 5,5,0);
        checkOutput("gate_start_out", out, 1);
        hi_cycles = 1;
        applyStimulus(1,1,0, 5,5,0);
        if (out) hi_cycles++;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1,0,0, 5,5,0);
            checkOutput("gate_hold_out", out, 1);
            checkOutput("gate_hold_done", done, 0);
            hi_cycles++;
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1,1,0, 5,5,0);
            if (!out) break;
            hi_cycles++;
        end
        checkOutput("gate_high_span", hi_cycles, 9);
        checkOutput("gate_low_busy", busy, 1);
        applyStimulus(1,1,0, 5,5,0);
        checkOutput("gate_low2_out", out, 0);
        applyStimulus(0,1,0, 5,5,0);
        checkOutput("midlow_rst_out", out, 0);
        checkOutput("midlow_rst_busy", busy, 0);
        checkOutput("midlow_rst_done", done, 0);
        applyStimulus(1,1,0, 5,5,0);
        checkOutput("after_rst_done", done, 0);
        checkOutput("after_rst_busy", busy, 0);

        // Maximum high length must not wrap to a short phase.
        applyStimulus(1,1,1, '1,0,1);
        for (int i = 0; i < 30; i++) applyStimulus(1,1,0, 0,0,0);
        checkOutput("maxlen_out", out, 1);
        checkOutput("maxlen_busy", busy, 1);
        applyStimulus(0,1,0, 0,0,0);
        checkOutput("maxlen_rst_out", out, 0);

        // Randomized run against the reference model.
        modelStep(0,1,0,0, 0,0,0);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            r_n  = ($urandom_range(0, 99) != 0);
            r_e  = ($urandom_range(0, 99) < 85);
            r_s  = ($urandom_range(0, 9) == 0);
`ifdef PULSE_TRAIN_GEN_ABORT_EN
            r_a  = ($urandom_range(0, 39) == 0);
`else
            r_a  = 1'b0;
`endif
            r_hl = W'($urandom_range(0, 3));
            r_ll = W'($urandom_range(0, 3));
            r_c  = W'($urandom_range(0, 4));
            abort = r_a;
            applyStimulus(r_n, r_e, r_s, r_hl, r_ll, r_c);
            modelStep(r_n, r_e, r_s, r_a, r_hl, r_ll, r_c);
            checkOutput("rand_out",  out,  m_out);
            checkOutput("rand_busy", busy, m_active);
            checkOutput("rand_done", done, m_done);
        end
        abort = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
